// File: rtl/mem_req_arbiter_pkg.sv
// ============================================================================
//  Module      : gm64_memarb_pkg
//  Description : Shared types and constants for the memCtrl request arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gm64_memarb_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } ArbState;

    // Requester port identifiers (one-bit grant encoding)
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_VIC = 1'b1;

    // Requester address layout: bit 24 selects the PSRAM chip
    localparam int BANK_BIT  = 24;
    localparam int ADDR_W    = 25;
    localparam int MC_ADDR_W = 24;
    localparam int DATA_W    = 8;
    localparam int CNT_W     = 8;

endpackage

`default_nettype wire

// File: rtl/mem_req_arbiter_if.sv
// ============================================================================
//  Module      : mem_req_arbiter_if
//  Description : Requester and memCtrl-side bundle for the memory arbiter.
//                Signal directions are named from the arbiter's viewpoint.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_req_arbiter_if;
    import gm64_memarb_pkg::*;

    // Requester port 0 (CPU) and port 1 (VIC-II / DMA)
    logic                   i_req0;
    logic                   i_we0;
    logic [ADDR_W-1:0]      i_addr0;
    logic [DATA_W-1:0]      i_wdata0;
    logic                   i_req1;
    logic                   i_we1;
    logic [ADDR_W-1:0]      i_addr1;
    logic [DATA_W-1:0]      i_wdata1;

    // Completion back to requesters
    logic                   o_ack0;
    logic                   o_ack1;
    logic [DATA_W-1:0]      o_rdata;
    logic                   o_err;

    // memCtrl transaction interface
    logic                   o_mc_cs;
    logic                   o_mc_write;
    logic                   o_mc_bank;
    logic [MC_ADDR_W-1:0]   o_mc_address;
    logic [DATA_W-1:0]      o_mc_wdata;
    logic                   i_mc_busy;
    logic                   i_mc_dataReady;
    logic [DATA_W-1:0]      i_mc_dataRead;

    // Arbiter side
    modport slave (
        input  i_req0, i_we0, i_addr0, i_wdata0,
        input  i_req1, i_we1, i_addr1, i_wdata1,
        output o_ack0, o_ack1, o_rdata, o_err,
        output o_mc_cs, o_mc_write, o_mc_bank, o_mc_address, o_mc_wdata,
        input  i_mc_busy, i_mc_dataReady, i_mc_dataRead
    );

    // Requesters plus memCtrl side
    modport master (
        output i_req0, i_we0, i_addr0, i_wdata0,
        output i_req1, i_we1, i_addr1, i_wdata1,
        input  o_ack0, o_ack1, o_rdata, o_err,
        input  o_mc_cs, o_mc_write, o_mc_bank, o_mc_address, o_mc_wdata,
        output i_mc_busy, i_mc_dataReady, i_mc_dataRead
    );

endinterface

`default_nettype wire

// File: rtl/mem_req_arbiter_rr_arb2.sv
// ============================================================================
//  Module      : rr_arb2
//  Description : Combinational two-way round-robin grant. A lone request
//                wins outright; on contention the port that did not win the
//                previous contention is chosen.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
    import gm64_memarb_pkg::*;
(
    input  wire logic [1:0] i_req,
    input  wire logic       i_last_grant,
    output logic            o_valid,
    output logic            o_port,
    output logic            o_contend
);

    // Pick the winning port from the request pair and contention history
    always_comb begin
        o_valid   = |i_req;
        o_contend = &i_req;
        if (o_contend) begin
            o_port = ~i_last_grant;
        end else if (i_req[1]) begin
            o_port = PORT_VIC;
        end else begin
            o_port = PORT_CPU;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_req_arbiter.sv
// ============================================================================
//  Module      : mem_req_arbiter
//  Description : Arbitrates the CPU and VIC-II/DMA requesters onto memCtrl's
//                single-transaction interface, drives the active-low cs
//                handshake, returns read data with a one-cycle ack per port
//                and aborts transactions that exceed a watchdog limit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_req_arbiter #(
    parameter int                TIMEOUT_CYCLES = 255,
    parameter logic [7:0]        ERR_DATA       = 8'hFF
) (
    input  wire logic            i_clkRAM,
    input  wire logic            reset,
    mem_req_arbiter_if.slave     bus
);
    import gm64_memarb_pkg::*;

    localparam logic [CNT_W-1:0] c_timeout_limit = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_max       = {CNT_W{1'b1}};

    ArbState                state_q, state_d;
    logic                   grant_q, grant_d;
    logic                   last_grant_q, last_grant_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   mc_cs_q, mc_cs_d;
    logic                   mc_write_q, mc_write_d;
    logic                   mc_bank_q, mc_bank_d;
    logic [MC_ADDR_W-1:0]   mc_address_q, mc_address_d;
    logic [DATA_W-1:0]      mc_wdata_q, mc_wdata_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   ack0_q, ack0_d;
    logic                   ack1_q, ack1_d;
    logic                   err_q, err_d;

    logic                   arb_valid;
    logic                   arb_port;
    logic                   arb_contend;
    logic                   timeout_hit;
    logic                   wait_done;
    logic [CNT_W-1:0]       cnt_inc;

    rr_arb2 u_rr_arb2 (
        .i_req        ({bus.i_req1, bus.i_req0}),
        .i_last_grant (last_grant_q),
        .o_valid      (arb_valid),
        .o_port       (arb_port),
        .o_contend    (arb_contend)
    );

    // A write finishes on busy falling; a read also needs dataReady
    assign wait_done   = !bus.i_mc_busy && (mc_write_q || bus.i_mc_dataReady);
    assign timeout_hit = (cnt_q >= c_timeout_limit);
    assign cnt_inc     = (cnt_q == c_cnt_max) ? cnt_q : cnt_q + 1'b1;

    // State and registered outputs; reset abandons any transaction silently
    always_ff @(posedge i_clkRAM or negedge reset) begin
        if (!reset) begin
            state_q      <= ARB_IDLE;
            grant_q      <= PORT_CPU;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            mc_cs_q      <= 1'b1;
            mc_write_q   <= 1'b0;
            mc_bank_q    <= 1'b0;
            mc_address_q <= '0;
            mc_wdata_q   <= '0;
            rdata_q      <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mc_cs_q      <= mc_cs_d;
            mc_write_q   <= mc_write_d;
            mc_bank_q    <= mc_bank_d;
            mc_address_q <= mc_address_d;
            mc_wdata_q   <= mc_wdata_d;
            rdata_q      <= rdata_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            err_q        <= err_d;
        end
    end

    // Sequence grant -> issue -> wait for memCtrl -> one-cycle done
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (!bus.i_mc_busy && arb_valid) begin
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (bus.i_mc_busy) begin
                    state_d = ARB_WAIT;
                end else if (timeout_hit) begin
                    state_d = ARB_DONE;
                end
            end
            ARB_WAIT: begin
                if (wait_done || timeout_hit) begin
                    state_d = ARB_DONE;
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Next values of the grant, watchdog and all registered outputs
    always_comb begin
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mc_cs_d      = mc_cs_q;
        mc_write_d   = mc_write_q;
        mc_bank_d    = mc_bank_q;
        mc_address_d = mc_address_q;
        mc_wdata_d   = mc_wdata_q;
        rdata_d      = rdata_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (!bus.i_mc_busy && arb_valid) begin
                    grant_d = arb_port;
                    if (arb_contend) begin
                        last_grant_d = arb_port;
                    end
                    mc_cs_d = 1'b0;
                    cnt_d   = '0;
                    if (arb_port == PORT_VIC) begin
                        mc_write_d   = bus.i_we1;
                        mc_bank_d    = bus.i_addr1[BANK_BIT];
                        mc_address_d = bus.i_addr1[MC_ADDR_W-1:0];
                        mc_wdata_d   = bus.i_wdata1;
                    end else begin
                        mc_write_d   = bus.i_we0;
                        mc_bank_d    = bus.i_addr0[BANK_BIT];
                        mc_address_d = bus.i_addr0[MC_ADDR_W-1:0];
                        mc_wdata_d   = bus.i_wdata0;
                    end
                end
            end
            ARB_ISSUE: begin
                if (bus.i_mc_busy) begin
                    // memCtrl accepted: raise cs so its edge detect re-arms
                    mc_cs_d = 1'b1;
                    cnt_d   = cnt_inc;
                end else if (timeout_hit) begin
                    mc_cs_d = 1'b1;
                    ack0_d  = (grant_q == PORT_CPU);
                    ack1_d  = (grant_q == PORT_VIC);
                    err_d   = 1'b1;
                    if (!mc_write_q) begin
                        rdata_d = ERR_DATA;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ARB_WAIT: begin
                if (wait_done) begin
                    ack0_d = (grant_q == PORT_CPU);
                    ack1_d = (grant_q == PORT_VIC);
                    if (!mc_write_q) begin
                        rdata_d = bus.i_mc_dataRead;
                    end
                end else if (timeout_hit) begin
                    ack0_d = (grant_q == PORT_CPU);
                    ack1_d = (grant_q == PORT_VIC);
                    err_d  = 1'b1;
                    if (!mc_write_q) begin
                        rdata_d = ERR_DATA;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.o_ack0       = ack0_q;
    assign bus.o_ack1       = ack1_q;
    assign bus.o_rdata      = rdata_q;
    assign bus.o_err        = err_q;
    assign bus.o_mc_cs      = mc_cs_q;
    assign bus.o_mc_write   = mc_write_q;
    assign bus.o_mc_bank    = mc_bank_q;
    assign bus.o_mc_address = mc_address_q;
    assign bus.o_mc_wdata   = mc_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
// ============================================================================
//  Module      : tb_mem_req_arbiter
//  Description : Self-checking bench for mem_req_arbiter with a behavioural
//                memCtrl model and an expected-transaction scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_req_arbiter;
    import gm64_memarb_pkg::*;

    localparam int TIMEOUT = 255;
    localparam int WAITC   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mem_req_arbiter_if bus();

    mem_req_arbiter #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .ERR_DATA       (8'hFF)
    ) u_dut (
        .i_clkRAM (clk),
        .reset    (rst_n),
        .bus      (bus)
    );

    typedef struct {
        int          port;
        logic        we;
        logic [24:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural memCtrl model ----------------
    bit         pwr_mode    = 1'b1;
    bit         hang_mode   = 1'b0;
    logic [7:0] model_rdata = 8'h00;
    int         m_cnt       = 0;
    logic       m_we        = 1'b0;
    logic       m_prev_cs   = 1'b1;

    always @(negedge clk) begin
        if (pwr_mode) begin
            bus.i_mc_busy      = 1'b1;
            bus.i_mc_dataReady = 1'b0;
            bus.i_mc_dataRead  = 8'h00;
            m_cnt              = 0;
        end else if (hang_mode) begin
            bus.i_mc_busy      = 1'b0;
            bus.i_mc_dataReady = 1'b0;
            m_cnt              = 0;
        end else if (m_cnt != 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                bus.i_mc_busy      = 1'b0;
                bus.i_mc_dataReady = !m_we;
                bus.i_mc_dataRead  = model_rdata;
            end
        end else begin
            bus.i_mc_busy      = 1'b0;
            bus.i_mc_dataReady = 1'b0;
            if (m_prev_cs && !bus.o_mc_cs) begin
                bus.i_mc_busy = 1'b1;
                m_we          = bus.o_mc_write;
                m_cnt         = m_we ? 16 : 16 + WAITC;
            end
        end
        m_prev_cs = bus.o_mc_cs;
    end

    // ---------------- scoreboard monitor ----------------
    exp_t mon_e;
    logic mon_prev_cs = 1'b1;

    always @(negedge clk) begin
        if (mon_prev_cs && !bus.o_mc_cs) begin
            if (sb_q.size() == 0) begin
                chk("cs_unexpected", 1, 0);
            end else begin
                mon_e = sb_q[0];
                chk("mc_address", 32'(bus.o_mc_address), 32'(mon_e.addr[23:0]));
                chk("mc_bank",    32'(bus.o_mc_bank),    32'(mon_e.addr[24]));
                chk("mc_write",   32'(bus.o_mc_write),   32'(mon_e.we));
                if (mon_e.we) chk("mc_wdata", 32'(bus.o_mc_wdata), 32'(mon_e.wdata));
            end
        end
        if (bus.o_ack0 || bus.o_ack1) begin
            chk("ack_overlap", 32'(bus.o_ack0 & bus.o_ack1), 0);
            if (sb_q.size() == 0) begin
                chk("ack_unexpected", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("ack_port", bus.o_ack1 ? 32'd1 : 32'd0, 32'(mon_e.port));
                chk("ack_err",  32'(bus.o_err), 32'(mon_e.err));
                if (!mon_e.we) chk("ack_rdata", 32'(bus.o_rdata), 32'(mon_e.rdata));
            end
        end else if (bus.o_err) begin
            chk("err_stray", 1, 0);
        end
        mon_prev_cs = bus.o_mc_cs;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_txn(input int port, input logic we, input logic [24:0] addr,
                              input logic [7:0] wd, input logic [7:0] rd, input logic err);
        exp_t e;
        e.port = port; e.we = we; e.addr = addr; e.wdata = wd; e.rdata = rd; e.err = err;
        sb_q.push_back(e);
    endtask

    task automatic drive_req(input int port, input logic we, input logic [24:0] addr, input logic [7:0] wd);
        if (port == 0) begin
            bus.i_req0 = 1'b1; bus.i_we0 = we; bus.i_addr0 = addr; bus.i_wdata0 = wd;
        end else begin
            bus.i_req1 = 1'b1; bus.i_we1 = we; bus.i_addr1 = addr; bus.i_wdata1 = wd;
        end
    endtask

    task automatic drop_req(input int port);
        if (port == 0) bus.i_req0 = 1'b0;
        else           bus.i_req1 = 1'b0;
    endtask

    task automatic wait_ack(input int port, input int max_cyc, input string tag, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < max_cyc) begin
            tick();
            cyc++;
            seen = (port == 0) ? bus.o_ack0 : bus.o_ack1;
        end
        if (!seen) chk({tag, "_ack_timeout"}, 0, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int  cyc;
        bit  flag;
        int  p;
        int  issued0;
        int  issued1;

        bus.i_req0 = 1'b0; bus.i_we0 = 1'b0; bus.i_addr0 = '0; bus.i_wdata0 = '0;
        bus.i_req1 = 1'b0; bus.i_we1 = 1'b0; bus.i_addr1 = '0; bus.i_wdata1 = '0;

        repeat (3) tick();
        chk("rst_cs",      32'(bus.o_mc_cs), 1);
        chk("rst_ack0",    32'(bus.o_ack0), 0);
        chk("rst_ack1",    32'(bus.o_ack1), 0);
        chk("rst_err",     32'(bus.o_err), 0);
        chk("rst_rdata",   32'(bus.o_rdata), 0);
        chk("rst_address", 32'(bus.o_mc_address), 0);
        chk("rst_write",   32'(bus.o_mc_write), 0);
        rst_n = 1'b1;

        // Power-up: memCtrl busy for a long init, request must wait
        expect_txn(0, 1'b1, 25'h0_000010, 8'h11, 8'h00, 1'b0);
        drive_req(0, 1'b1, 25'h0_000010, 8'h11);
        flag = 1'b0;
        repeat (15000) begin
            tick();
            if (!bus.o_mc_cs || bus.o_ack0) flag = 1'b1;
        end
        chk("pwr_cs_held", 32'(flag), 0);
        pwr_mode = 1'b0;
        wait_ack(0, 200, "pwr", cyc);
        drop_req(0);
        tick();

        // Single write on port 0
        expect_txn(0, 1'b1, 25'h0_001234, 8'hA5, 8'h00, 1'b0);
        drive_req(0, 1'b1, 25'h0_001234, 8'hA5);
        wait_ack(0, 200, "wr", cyc);
        drop_req(0);
        chk("wr_latency_window", 32'(cyc >= 16 && cyc <= 26), 1);
        tick();

        // Single read on port 1, bank 1
        model_rdata = 8'h3C;
        expect_txn(1, 1'b0, 25'h1_00ABCD, 8'h00, 8'h3C, 1'b0);
        drive_req(1, 1'b0, 25'h1_00ABCD, 8'h00);
        wait_ack(1, 200, "rd", cyc);
        drop_req(1);
        repeat (5) tick();
        chk("rd_hold", 32'(bus.o_rdata), 32'h3C);

        // Contention: grants must alternate 0,1,0,1
        expect_txn(0, 1'b1, 25'h0_000100, 8'h50, 8'h00, 1'b0);
        expect_txn(1, 1'b1, 25'h1_000200, 8'h61, 8'h00, 1'b0);
        expect_txn(0, 1'b1, 25'h0_000300, 8'h72, 8'h00, 1'b0);
        expect_txn(1, 1'b1, 25'h1_000400, 8'h83, 8'h00, 1'b0);
        drive_req(0, 1'b1, 25'h0_000100, 8'h50);
        drive_req(1, 1'b1, 25'h1_000200, 8'h61);
        issued0 = 1;
        issued1 = 1;
        for (int n = 0; n < 4; n++) begin
            flag = 1'b0;
            cyc  = 0;
            while (!flag && cyc < 200) begin
                tick();
                cyc++;
                flag = bus.o_ack0 || bus.o_ack1;
            end
            if (!flag) begin
                chk("cont_ack_timeout", 0, 1);
                break;
            end
            p = bus.o_ack1 ? 1 : 0;
            drop_req(p);
            tick();
            if (p == 0 && issued0 < 2) begin
                drive_req(0, 1'b1, 25'h0_000300, 8'h72);
                issued0++;
            end else if (p == 1 && issued1 < 2) begin
                drive_req(1, 1'b1, 25'h1_000400, 8'h83);
                issued1++;
            end
        end
        repeat (3) tick();

        // Timeout: memCtrl never responds
        hang_mode = 1'b1;
        expect_txn(0, 1'b0, 25'h0_0000AA, 8'h00, 8'hFF, 1'b1);
        drive_req(0, 1'b0, 25'h0_0000AA, 8'h00);
        wait_ack(0, 400, "to", cyc);
        drop_req(0);
        chk("to_latency", 32'(cyc), 32'(TIMEOUT + 2));
        tick();
        chk("to_cs_idle",   32'(bus.o_mc_cs), 1);
        chk("to_err_pulse", 32'(bus.o_err), 0);
        chk("to_rdata_hold", 32'(bus.o_rdata), 32'hFF);
        hang_mode = 1'b0;
        repeat (3) tick();

        // Reset while waiting on a read
        model_rdata = 8'h77;
        expect_txn(1, 1'b0, 25'h1_000500, 8'h00, 8'h77, 1'b0);
        drive_req(1, 1'b0, 25'h1_000500, 8'h00);
        flag = 1'b0;
        cyc  = 0;
        while (!flag && cyc < 50) begin
            tick();
            cyc++;
            flag = bus.i_mc_busy && bus.o_mc_cs;
        end
        chk("rst_reach_wait", 32'(flag), 1);
        rst_n = 1'b0;
        sb_q.delete();
        drop_req(1);
        repeat (3) begin
            tick();
            chk("rstw_cs",   32'(bus.o_mc_cs), 1);
            chk("rstw_ack",  32'(bus.o_ack0 | bus.o_ack1), 0);
        end
        chk("rstw_rdata", 32'(bus.o_rdata), 0);
        rst_n = 1'b1;
        flag = 1'b0;
        cyc  = 0;
        while (!flag && cyc < 50) begin
            tick();
            cyc++;
            flag = !bus.i_mc_busy;
        end
        chk("rstw_busy_fall", 32'(flag), 1);
        repeat (3) tick();
        chk("rstw_cs_idle", 32'(bus.o_mc_cs), 1);

        // Fresh request on port 1 after reset
        expect_txn(1, 1'b1, 25'h1_000600, 8'h5A, 8'h00, 1'b0);
        drive_req(1, 1'b1, 25'h1_000600, 8'h5A);
        wait_ack(1, 200, "post_rst", cyc);
        drop_req(1);
        repeat (3) tick();

        chk("sb_empty", 32'(sb_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
